// File: rtl/alu_pkg.sv
// Shared ALU definitions: word width, opcode encodings and the word type.
package alu_pkg;

  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam logic [7:0] xADD  = 8'h01;
  localparam logic [7:0] xADC  = 8'h02;
  localparam logic [7:0] xSUB  = 8'h03;
  localparam logic [7:0] xSUC  = 8'h04;
  localparam logic [7:0] xMUL8 = 8'h05;
  localparam logic [7:0] xMUL6 = 8'h06;
  localparam logic [7:0] xDIV8 = 8'h07;
  localparam logic [7:0] xDIV6 = 8'h08;
  localparam logic [7:0] xCMP  = 8'h09;
  localparam logic [7:0] xAND  = 8'h0A;
  localparam logic [7:0] xNEG  = 8'h0B;
  localparam logic [7:0] xNOT  = 8'h0C;
  localparam logic [7:0] xOR   = 8'h0D;
  localparam logic [7:0] xSHL  = 8'h0E;
  localparam logic [7:0] xSHR  = 8'h0F;
  localparam logic [7:0] xXOR  = 8'h10;
  localparam logic [7:0] xTEST = 8'h11;

endpackage

// File: rtl/alu_if.sv
// Operand/opcode inputs and registered result/flag outputs of the ALU.
interface alu_if;
  import alu_pkg::*;

  word_t      a;
  word_t      b;
  logic [7:0] op;
  logic       cf;
  word_t      acc;
  word_t      c;
  logic       c_flag;
  logic       z_flag;
  logic       o_flag;

  modport master (output a, b, op, cf, input acc, c, c_flag, z_flag, o_flag);
  modport slave  (input a, b, op, cf, output acc, c, c_flag, z_flag, o_flag);
endinterface

// File: rtl/divu16.sv
// Combinational unsigned restoring divider; a zero divisor yields an all-ones
// quotient, which the caller overrides.
module divu16
  import alu_pkg::*;
(
  input  word_t dividend,
  input  word_t divisor,
  output word_t quotient,
  output word_t remainder
);

  logic [WORD_W:0] rem;
  word_t           quo;

  always_comb begin
    rem = '0;
    quo = '0;
    for (int unsigned k = 0; k < WORD_W; k++) begin
      rem = {rem[WORD_W-1:0], dividend[WORD_W-1-k]};
      if (rem >= {1'b0, divisor}) begin
        rem              = rem - {1'b0, divisor};
        quo[WORD_W-1-k]  = 1'b1;
      end
    end
  end

  assign quotient  = quo;
  assign remainder = rem[WORD_W-1:0];

endmodule

// File: rtl/alu.sv
// 16-bit ALU: combinational result/flag selection into one output register
// stage; unused opcodes hold every output.
module alu
  import alu_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  alu_if.slave  bus
);

  word_t acc_q, acc_d, c_q, c_d;
  logic  c_flag_q, c_flag_d, z_flag_q, z_flag_d, o_flag_q, o_flag_d;

  logic            carry_in, borrow_in;
  logic [WORD_W:0] add_s, sub_s;
  logic            add_ovf, sub_ovf;
  logic [2*WORD_W-1:0] prod;
  word_t           mul8, div_n, div_d, div_q, div_r;
  logic            is_div8;

  always_comb begin
    carry_in  = (bus.op == xADC) & bus.cf;
    borrow_in = (bus.op == xSUC) & bus.cf;
    add_s     = {1'b0, bus.a} + {1'b0, bus.b} + {{WORD_W{1'b0}}, carry_in};
    // bit WORD_W of the 17-bit difference is the borrow out
    sub_s     = {1'b0, bus.a} - {1'b0, bus.b} - {{WORD_W{1'b0}}, borrow_in};
    add_ovf   = (bus.a[WORD_W-1] == bus.b[WORD_W-1]) && (add_s[WORD_W-1] != bus.a[WORD_W-1]);
    sub_ovf   = (bus.a[WORD_W-1] != bus.b[WORD_W-1]) && (sub_s[WORD_W-1] != bus.a[WORD_W-1]);
    prod      = (2*WORD_W)'(bus.a) * (2*WORD_W)'(bus.b);
    mul8      = WORD_W'(bus.a[7:0]) * WORD_W'(bus.b[7:0]);
    is_div8   = (bus.op == xDIV8);
    div_n     = is_div8 ? {8'h00, bus.a[7:0]} : bus.a;
    div_d     = is_div8 ? {8'h00, bus.b[7:0]} : bus.b;
  end

  divu16 u_div (
    .dividend  (div_n),
    .divisor   (div_d),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_comb begin
    acc_d    = acc_q;
    c_d      = c_q;
    c_flag_d = c_flag_q;
    z_flag_d = z_flag_q;
    o_flag_d = o_flag_q;
    unique case (bus.op)
      xADD, xADC: begin
        acc_d    = add_s[WORD_W-1:0];
        c_d      = '0;
        c_flag_d = add_s[WORD_W];
        o_flag_d = add_ovf;
        z_flag_d = (add_s[WORD_W-1:0] == '0);
      end
      xSUB, xSUC, xCMP: begin
        if (bus.op != xCMP) begin
          acc_d = sub_s[WORD_W-1:0];
          c_d   = '0;
        end
        c_flag_d = sub_s[WORD_W];
        o_flag_d = sub_ovf;
        z_flag_d = (sub_s[WORD_W-1:0] == '0);
      end
      xMUL8: begin
        acc_d    = mul8;
        c_d      = '0;
        c_flag_d = 1'b0;
        o_flag_d = 1'b0;
        z_flag_d = (mul8 == '0);
      end
      xMUL6: begin
        acc_d    = prod[WORD_W-1:0];
        c_d      = prod[2*WORD_W-1:WORD_W];
        c_flag_d = 1'b0;
        o_flag_d = 1'b0;
        z_flag_d = (prod == '0);
      end
      xDIV8, xDIV6: begin
        c_flag_d = 1'b0;
        if (div_d == '0) begin
          acc_d    = '1;
          c_d      = bus.a;
          o_flag_d = 1'b1;
          z_flag_d = 1'b0;
        end else begin
          acc_d    = is_div8 ? {div_r[7:0], div_q[7:0]} : div_q;
          c_d      = is_div8 ? '0 : div_r;
          o_flag_d = 1'b0;
          z_flag_d = is_div8 ? ({div_r[7:0], div_q[7:0]} == '0) : (div_q == '0);
        end
      end
      xAND, xOR, xXOR, xNEG, xNOT: begin
        case (bus.op)
          xAND:    acc_d = bus.a & bus.b;
          xOR:     acc_d = bus.a | bus.b;
          xXOR:    acc_d = bus.a ^ bus.b;
          xNEG:    acc_d = '0 - bus.a;
          default: acc_d = ~bus.a;
        endcase
        c_d      = '0;
        c_flag_d = 1'b0;
        o_flag_d = 1'b0;
        z_flag_d = (acc_d == '0);
      end
      xSHL, xSHR: begin
        acc_d    = (bus.op == xSHL) ? {bus.a[WORD_W-2:0], 1'b0} : {1'b0, bus.a[WORD_W-1:1]};
        c_d      = '0;
        c_flag_d = (bus.op == xSHL) ? bus.a[WORD_W-1] : bus.a[0];
        o_flag_d = 1'b0;
        z_flag_d = (acc_d == '0);
      end
      xTEST: begin
        c_flag_d = 1'b0;
        o_flag_d = 1'b0;
        z_flag_d = ((bus.a & bus.b) == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      c_q      <= '0;
      c_flag_q <= 1'b0;
      z_flag_q <= 1'b0;
      o_flag_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      c_q      <= c_d;
      c_flag_q <= c_flag_d;
      z_flag_q <= z_flag_d;
      o_flag_q <= o_flag_d;
    end
  end

  assign bus.acc    = acc_q;
  assign bus.c      = c_q;
  assign bus.c_flag = c_flag_q;
  assign bus.z_flag = z_flag_q;
  assign bus.o_flag = o_flag_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases followed by random operations
// compared against an integer-arithmetic reference model.
module tb_alu;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  int m_acc, m_c, m_cf, m_z, m_o;

  alu_if bus ();

  alu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int sgn(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  function automatic int ovf(input int v);
    return (v > 32767 || v < -32768) ? 1 : 0;
  endfunction

  task automatic model(input int rst, input int op, input int a, input int b, input int cin);
    int s, r, al, bl;
    longint p;
    if (rst != 0) begin
      m_acc = 0; m_c = 0; m_cf = 0; m_z = 0; m_o = 0;
      return;
    end
    case (op)
      1, 2: begin
        s = a + b + ((op == 2) ? cin : 0);
        m_acc = s % 65536; m_c = 0; m_cf = (s > 65535);
        m_o = ovf(sgn(a) + sgn(b) + ((op == 2) ? cin : 0)); m_z = (m_acc == 0);
      end
      3, 4, 9: begin
        s = a - b - ((op == 4) ? cin : 0);
        r = (s < 0) ? s + 65536 : s;
        m_cf = (s < 0); m_z = (r == 0);
        m_o = ovf(sgn(a) - sgn(b) - ((op == 4) ? cin : 0));
        if (op != 9) begin m_acc = r; m_c = 0; end
      end
      5: begin
        m_acc = (a % 256) * (b % 256); m_c = 0; m_cf = 0; m_o = 0; m_z = (m_acc == 0);
      end
      6: begin
        p = longint'(a) * longint'(b);
        m_acc = int'(p % 65536); m_c = int'(p / 65536); m_cf = 0; m_o = 0; m_z = (p == 0);
      end
      7, 8: begin
        al = (op == 7) ? a % 256 : a;
        bl = (op == 7) ? b % 256 : b;
        m_cf = 0;
        if (bl == 0) begin
          m_acc = 65535; m_c = a; m_o = 1; m_z = 0;
        end else begin
          m_acc = (op == 7) ? (al % bl) * 256 + al / bl : al / bl;
          m_c = (op == 7) ? 0 : al % bl;
          m_o = 0; m_z = (m_acc == 0);
        end
      end
      10, 11, 12, 13, 16: begin
        case (op)
          10: m_acc = a & b;
          13: m_acc = a | b;
          16: m_acc = a ^ b;
          11: m_acc = (65536 - a) % 65536;
          default: m_acc = 65535 - a;
        endcase
        m_c = 0; m_cf = 0; m_o = 0; m_z = (m_acc == 0);
      end
      14: begin m_acc = (a * 2) % 65536; m_c = 0; m_cf = (a >= 32768); m_o = 0; m_z = (m_acc == 0); end
      15: begin m_acc = a / 2; m_c = 0; m_cf = a % 2; m_o = 0; m_z = (m_acc == 0); end
      17: begin m_z = ((a & b) == 0); m_cf = 0; m_o = 0; end
      default: ;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int rst, input int op, input int a, input int b, input int cin);
    @(negedge clk);
    reset  = (rst != 0);
    bus.op = 8'(op);
    bus.a  = 16'(a);
    bus.b  = 16'(b);
    bus.cf = (cin != 0);
    @(posedge clk);
    #1;
    model(rst, op, a, b, cin);
    check($sformatf("acc op=%02h", op),    {16'h0, bus.acc},    32'(m_acc));
    check($sformatf("c op=%02h", op),      {16'h0, bus.c},      32'(m_c));
    check($sformatf("c_flag op=%02h", op), {31'h0, bus.c_flag}, 32'(m_cf));
    check($sformatf("z_flag op=%02h", op), {31'h0, bus.z_flag}, 32'(m_z));
    check($sformatf("o_flag op=%02h", op), {31'h0, bus.o_flag}, 32'(m_o));
  endtask

  initial begin
    int op, a, b, sel, rst;
    reset = 1'b1; bus.op = 8'h00; bus.a = '0; bus.b = '0; bus.cf = 1'b0;

    step(1, 8'h01, 16'h0001, 16'h0001, 0);
    step(0, 8'h00, 16'h1111, 16'h2222, 0);
    step(0, 8'h01, 16'hFFFF, 16'h0001, 0);
    step(0, 8'h02, 16'h7FFF, 16'h0000, 1);
    step(0, 8'h03, 16'h0000, 16'h0001, 0);
    step(0, 8'h04, 16'h8000, 16'h0001, 1);
    step(0, 8'h06, 16'h1234, 16'h0100, 0);
    step(0, 8'h08, 16'h0064, 16'h0007, 0);
    step(0, 8'h08, 16'hABCD, 16'h0000, 0);
    step(0, 8'h07, 16'h0010, 16'h0000, 0);
    step(0, 8'h07, 16'h0011, 16'h0005, 0);
    step(0, 8'h07, 16'h0011, 16'h0F00, 0);
    step(0, 8'h01, 16'h1200, 16'h0034, 0);
    step(0, 8'h09, 16'h0005, 16'h0005, 0);
    step(0, 8'h0E, 16'h8001, 16'h0000, 0);
    step(0, 8'h0F, 16'h8001, 16'h0000, 0);
    step(0, 8'h06, 16'h0000, 16'hFFFF, 0);
    step(0, 8'h11, 16'hF0F0, 16'h0F0F, 0);
    step(0, 8'h0B, 16'h8000, 16'h0000, 0);
    step(0, 8'hFF, 16'h1234, 16'h5678, 1);

    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 19);
      op  = (sel <= 17) ? sel : $urandom_range(18, 255);
      sel = $urandom_range(0, 9);
      a   = (sel == 0) ? (($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h8000)
                       : (sel == 1) ? 16'h7FFF : int'($urandom_range(0, 65535));
      sel = $urandom_range(0, 9);
      b   = (sel == 0) ? 0 : (sel == 1) ? int'($urandom_range(0, 255)) * 256
                       : (sel == 2) ? int'($urandom_range(1, 15)) : int'($urandom_range(0, 65535));
      rst = ($urandom_range(0, 39) == 0) ? 1 : 0;
      step(rst, op, a, b, int'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
